// File: rtl/rggen_address_decoder_pipelined.sv
// rtl/rggen_address_decoder_pipelined.sv - registered multi-window address decoder with valid/ready output stage
// Optional sticky miss capture: RGGEN_ADDRESS_DECODER_STICKY_ERROR_EN
module rggen_address_decoder_pipelined #(
   parameter int                       WIDTH           = 8,
   parameter int                       BUS_WIDTH       = 32,
   parameter int                       WINDOWS         = 2,
   parameter logic [WINDOWS*WIDTH-1:0] START_ADDRESSES = {WINDOWS*WIDTH{1'b0}},
   parameter logic [WINDOWS*32-1:0]    BYTE_SIZES      = {WINDOWS{32'd4}},
   parameter logic [WINDOWS-1:0]       READABLE        = {WINDOWS{1'b1}},
   parameter logic [WINDOWS-1:0]       WRITABLE        = {WINDOWS{1'b1}}
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [WIDTH-1:0]   i_address,
   input  logic [1:0]         i_access,
   input  logic [WINDOWS-1:0] i_additional_match,
`ifdef RGGEN_ADDRESS_DECODER_STICKY_ERROR_EN
   input  logic               i_clear,
   output logic               o_sticky_miss,
   output logic [WIDTH-1:0]   o_miss_address,
`endif
   output logic               o_valid,
   input  logic               i_ready,
   output logic [WINDOWS-1:0] o_select,
   output logic               o_miss,
   output logic               o_access_error
);

   localparam int LSB = $clog2(BUS_WIDTH) - 3;
   localparam int AW  = WIDTH - LSB;

   logic [AW-1:0]      w_index;
   logic [WINDOWS-1:0] w_addr_hit;
   logic [WINDOWS-1:0] w_perm_ok;
   logic [WINDOWS-1:0] w_full_hit;
   logic [WINDOWS-1:0] w_select;
   logic               w_miss;
   logic               w_access_error;
   logic               w_accept;
   logic               w_unused_access;

   logic               r_valid;
   logic [WINDOWS-1:0] r_select;
   logic               r_miss;
   logic               r_access_error;

   assign w_index         = i_address[WIDTH-1:LSB];
   assign w_unused_access = i_access[1];

   for (genvar k = 0; k < WINDOWS; k++) begin : g_window
      localparam logic [WIDTH-1:0] START    = START_ADDRESSES[k*WIDTH +: WIDTH];
      localparam logic [31:0]      SIZE     = BYTE_SIZES[k*32 +: 32];
      localparam logic [WIDTH-1:0] END_ADDR = WIDTH'(START + SIZE - 32'd1);
      localparam logic [AW-1:0]    BEGIN_IX = START[WIDTH-1:LSB];
      localparam logic [AW-1:0]    END_IX   = END_ADDR[WIDTH-1:LSB];

      // Drop bound compares that are always true so no constant comparator is built.
      if (BEGIN_IX == '0 && END_IX == '1) begin : g_all
         assign w_addr_hit[k] = 1'b1;
      end else if (BEGIN_IX == '0) begin : g_upper
         assign w_addr_hit[k] = (w_index <= END_IX);
      end else if (END_IX == '1) begin : g_lower
         assign w_addr_hit[k] = (w_index >= BEGIN_IX);
      end else begin : g_both
         assign w_addr_hit[k] = (w_index >= BEGIN_IX) && (w_index <= END_IX);
      end

      assign w_perm_ok[k] = (READABLE[k] && WRITABLE[k]) ||
                            (READABLE[k] && !i_access[0]) ||
                            (WRITABLE[k] &&  i_access[0]);
   end

   assign w_full_hit     = w_addr_hit & w_perm_ok & i_additional_match;
   // Isolate the lowest set bit: lowest-index window wins on overlap.
   assign w_select       = w_full_hit & (~w_full_hit + WINDOWS'(1));
   assign w_miss         = ~|w_full_hit;
   assign w_access_error = w_miss && |(w_addr_hit & i_additional_match & ~w_perm_ok);

   assign o_ready  = !r_valid || i_ready;
   assign w_accept = i_valid && o_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid        <= 1'b0;
         r_select       <= '0;
         r_miss         <= 1'b0;
         r_access_error <= 1'b0;
      end else begin
         r_valid <= w_accept || (r_valid && !i_ready);
         if (w_accept) begin
            r_select       <= w_select;
            r_miss         <= w_miss;
            r_access_error <= w_access_error;
         end
      end
   end

   assign o_valid        = r_valid;
   assign o_select       = r_select;
   assign o_miss         = r_miss;
   assign o_access_error = r_access_error;

`ifdef RGGEN_ADDRESS_DECODER_STICKY_ERROR_EN
   logic             r_sticky_miss;
   logic [WIDTH-1:0] r_miss_address;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sticky_miss  <= 1'b0;
         r_miss_address <= '0;
      end else if (i_clear) begin
         r_sticky_miss  <= 1'b0;
         r_miss_address <= '0;
      end else if (w_accept && w_miss && !r_sticky_miss) begin
         r_sticky_miss  <= 1'b1;
         r_miss_address <= i_address;
      end
   end

   assign o_sticky_miss  = r_sticky_miss;
   assign o_miss_address = r_miss_address;
`endif

endmodule

// File: tb/tb_rggen_address_decoder_pipelined.sv
// tb/tb_rggen_address_decoder_pipelined.sv - directed self-checking bench for rggen_address_decoder_pipelined
// Covers RGGEN_ADDRESS_DECODER_STICKY_ERROR_EN when defined
module tb_rggen_address_decoder_pipelined;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_valid;
   logic       o_ready;
   logic [7:0] i_address;
   logic [1:0] i_access;
   logic [2:0] i_additional_match;
   logic       o_valid;
   logic       i_ready;
   logic [2:0] o_select;
   logic       o_miss;
   logic       o_access_error;
`ifdef RGGEN_ADDRESS_DECODER_STICKY_ERROR_EN
   logic       i_clear;
   logic       o_sticky_miss;
   logic [7:0] o_miss_address;
`endif

   int passed;
   int total;

   rggen_address_decoder_pipelined #(
      .WIDTH           (8),
      .BUS_WIDTH       (32),
      .WINDOWS         (3),
      .START_ADDRESSES ({8'h18, 8'h10, 8'h00}),
      .BYTE_SIZES      ({32'd8, 32'd16, 32'd4}),
      .READABLE        (3'b111),
      .WRITABLE        (3'b110)
   ) dut (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .i_valid            (i_valid),
      .o_ready            (o_ready),
      .i_address          (i_address),
      .i_access           (i_access),
      .i_additional_match (i_additional_match),
`ifdef RGGEN_ADDRESS_DECODER_STICKY_ERROR_EN
      .i_clear            (i_clear),
      .o_sticky_miss      (o_sticky_miss),
      .o_miss_address     (o_miss_address),
`endif
      .o_valid            (o_valid),
      .i_ready            (i_ready),
      .o_select           (o_select),
      .o_miss             (o_miss),
      .o_access_error     (o_access_error)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Called 1 time unit after a rising edge; returns 1 unit after the edge that accepts.
   task automatic req(input logic [7:0] a, input logic wr, input logic [2:0] m);
      i_valid            = 1'b1;
      i_address          = a;
      i_access           = {1'b0, wr};
      i_additional_match = m;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic test_reset;
      total++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", o_valid); else passed++;
      total++; if (o_select !== 3'b000) $display("FAIL reset_select got %b exp 000", o_select); else passed++;
      total++; if ({o_miss, o_access_error} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {o_miss, o_access_error}); else passed++;
      total++; if (o_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", o_ready); else passed++;
   endtask

   task automatic test_read_hit;
      req(8'h02, 1'b0, 3'b111);
      total++; if ({o_valid, o_select, o_miss, o_access_error} !== 6'b1_001_00)
         $display("FAIL read_0x02 got %b exp 100100", {o_valid, o_select, o_miss, o_access_error}); else passed++;
      req(8'h14, 1'b1, 3'b111);
      total++; if ({o_select, o_miss, o_access_error} !== 5'b010_00)
         $display("FAIL write_0x14 got %b exp 01000", {o_select, o_miss, o_access_error}); else passed++;
   endtask

   task automatic test_access_error;
      req(8'h00, 1'b1, 3'b111);
      total++; if ({o_select, o_miss, o_access_error} !== 5'b000_11)
         $display("FAIL write_ro got %b exp 00011", {o_select, o_miss, o_access_error}); else passed++;
      req(8'h00, 1'b1, 3'b110);
      total++; if ({o_select, o_miss, o_access_error} !== 5'b000_10)
         $display("FAIL write_ro_nomatch got %b exp 00010", {o_select, o_miss, o_access_error}); else passed++;
   endtask

   task automatic test_overlap;
      req(8'h1C, 1'b0, 3'b111);
      total++; if (o_select !== 3'b010) $display("FAIL overlap_low got %b exp 010", o_select); else passed++;
      req(8'h1C, 1'b0, 3'b101);
      total++; if (o_select !== 3'b100) $display("FAIL overlap_masked got %b exp 100", o_select); else passed++;
   endtask

   task automatic test_miss;
`ifdef RGGEN_ADDRESS_DECODER_STICKY_ERROR_EN
      i_clear = 1'b1;
      @(posedge i_clk); #1;
      i_clear = 1'b0;
      total++; if ({o_sticky_miss, o_miss_address} !== 9'h000)
         $display("FAIL sticky_preclear got %b/%h exp 0/00", o_sticky_miss, o_miss_address); else passed++;
`endif
      req(8'h20, 1'b0, 3'b111);
      total++; if ({o_select, o_miss, o_access_error} !== 5'b000_10)
         $display("FAIL miss_0x20 got %b exp 00010", {o_select, o_miss, o_access_error}); else passed++;
`ifdef RGGEN_ADDRESS_DECODER_STICKY_ERROR_EN
      total++; if ({o_sticky_miss, o_miss_address} !== {1'b1, 8'h20})
         $display("FAIL sticky_set got %b/%h exp 1/20", o_sticky_miss, o_miss_address); else passed++;
      req(8'h40, 1'b0, 3'b111);
      total++; if ({o_sticky_miss, o_miss_address} !== {1'b1, 8'h20})
         $display("FAIL sticky_keep got %b/%h exp 1/20", o_sticky_miss, o_miss_address); else passed++;
      i_clear = 1'b1;
      req(8'h44, 1'b0, 3'b111);
      i_clear = 1'b0;
      total++; if ({o_sticky_miss, o_miss_address} !== 9'h000)
         $display("FAIL sticky_clear got %b/%h exp 0/00", o_sticky_miss, o_miss_address); else passed++;
`endif
   endtask

   task automatic test_backpressure;
      i_ready = 1'b0;
      req(8'h20, 1'b0, 3'b111);
      // Offer a different request while stalled; it must not be taken.
      i_valid            = 1'b1;
      i_address          = 8'h10;
      i_access           = 2'b00;
      i_additional_match = 3'b111;
      for (int c = 0; c < 5; c++) begin
         total++; if ({o_ready, o_valid, o_select, o_miss, o_access_error} !== 7'b0_1_000_10)
            $display("FAIL stall_cycle%0d got %b exp 0100010", c, {o_ready, o_valid, o_select, o_miss, o_access_error}); else passed++;
         @(posedge i_clk); #1;
      end
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      total++; if ({o_valid, o_select, o_miss} !== 5'b1_010_0)
         $display("FAIL release_result got %b exp 10100", {o_valid, o_select, o_miss}); else passed++;
   endtask

   task automatic test_back_to_back;
      logic [7:0] addrs [4];
      logic       wrs   [4];
      logic [2:0] ms    [4];
      logic [3:0] exps  [4];
      addrs = '{8'h00, 8'h14, 8'h1C, 8'h30};
      wrs   = '{1'b0, 1'b0, 1'b1, 1'b0};
      ms    = '{3'b111, 3'b111, 3'b101, 3'b111};
      exps  = '{4'b001_0, 4'b010_0, 4'b100_0, 4'b000_1};
      for (int i = 0; i < 4; i++) begin
         i_valid            = 1'b1;
         i_address          = addrs[i];
         i_access           = {1'b0, wrs[i]};
         i_additional_match = ms[i];
         @(posedge i_clk); #1;
         total++; if ({o_valid, o_select, o_miss} !== {1'b1, exps[i]})
            $display("FAIL b2b_%0d got %b exp %b", i, {o_valid, o_select, o_miss}, {1'b1, exps[i]}); else passed++;
      end
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      total++; if (o_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", o_valid); else passed++;
   endtask

   task automatic test_async_reset;
      req(8'h02, 1'b0, 3'b111);
      i_rst_n = 1'b0;
      #1;
      total++; if ({o_valid, o_select, o_miss, o_access_error} !== 6'b0)
         $display("FAIL async_reset got %b exp 000000", {o_valid, o_select, o_miss, o_access_error}); else passed++;
      #2;
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      req(8'h1C, 1'b0, 3'b100);
      total++; if ({o_valid, o_select, o_miss, o_access_error} !== 6'b1_100_00)
         $display("FAIL post_reset got %b exp 110000", {o_valid, o_select, o_miss, o_access_error}); else passed++;
   endtask

   initial begin
      passed             = 0;
      total              = 0;
      i_rst_n            = 1'b0;
      i_valid            = 1'b0;
      i_address          = '0;
      i_access           = '0;
      i_additional_match = '0;
      i_ready            = 1'b1;
`ifdef RGGEN_ADDRESS_DECODER_STICKY_ERROR_EN
      i_clear            = 1'b0;
`endif
      repeat (2) @(posedge i_clk);
      #1;
      test_reset();
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      test_reset();
      test_read_hit();
      test_access_error();
      test_overlap();
      test_miss();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
